// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// ID/EX pipeline register for the 5-stage RISC-V core. It latches the decoded
// fields from ID and presents them to EX. It also detects load-use hazards and
// inserts a bubble for one, and kills the wrong-path ID instruction after a
// taken branch. It drives the PC and IF/ID stall and flush controls.
//
// Optional feature:
//   ID_EX_PERF_EN  when defined, bubble_cnt and flush_cnt are live 32-bit
//                  wrapping counters. When undefined, there are no counter
//                  flops and both outputs are tied to 0.
//
// Parameters:
//   XLEN    datapath width
//   CTRL_W  width of the opaque ALU/branch control bundle
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decoded fields from the ID stage
//   br_taken                     EX resolved a taken branch or jump this cycle
//   mem_stall                    data memory busy; freeze the pipeline
//   ex_*                         registered copies of the id_* fields for EX
//   pc_stall, ifid_stall         hold the PC and the IF/ID register
//   ifid_flush                   clear the IF/ID register
//   bubble_cnt, flush_cnt        performance counters
// ============================================================================
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [XLEN-1:0]   id_rdata1,
   input  logic [XLEN-1:0]   id_rdata2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_imm_sel,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_reg_write,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              br_taken,
   input  logic              mem_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [XLEN-1:0]   ex_rdata1,
   output logic [XLEN-1:0]   ex_rdata2,
   output logic [XLEN-1:0]   ex_imm,
   output logic              ex_imm_sel,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_reg_write,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              ifid_flush,
   output logic [31:0]       bubble_cnt,
   output logic [31:0]       flush_cnt
);

   // A load in EX whose destination register is read by a real ID instruction.
   // A load to x0 never stalls, because x0 is never written.
   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
   assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
   assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid
                   & (rs1_hit | rs2_hit);

   // A taken branch kills the ID instruction. Its hazard is then irrelevant,
   // so the flush suppresses the stall.
   assign pc_stall   = mem_stall | (load_use & ~br_taken);
   assign ifid_stall = pc_stall;
   assign ifid_flush = br_taken & ~mem_stall;

   // Reset and bubble both clear every EX field. A bubble carries zero
   // register indices, so the forwarding unit can never match on it.
   // NOTE: sequential state uses non-blocking (<=) assignments only. Every
   // flop then samples pre-edge values, and block order cannot matter.
   always_ff @(posedge clk) begin
      if (rst || (!mem_stall && (br_taken || load_use))) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_rdata1    <= '0;
         ex_rdata2    <= '0;
         ex_imm       <= '0;
         ex_imm_sel   <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_ctrl      <= '0;
      end else if (!mem_stall) begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_rdata1    <= id_rdata1;
         ex_rdata2    <= id_rdata2;
         ex_imm       <= id_imm;
         ex_imm_sel   <= id_imm_sel;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_reg_write <= id_reg_write;
         ex_ctrl      <= id_ctrl;
      end
   end

`ifdef ID_EX_PERF_EN
   // The counters wrap naturally at 32 bits. A branch flush that coincides
   // with a load-use hazard counts only as a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!mem_stall) begin
         if (br_taken)
            flush_cnt <= flush_cnt + 32'd1;
         else if (load_use)
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`else
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage
// ----------------------------------------------------------------------------
// Directed, self-checking bench for id_ex_stage. The expected counter values
// follow the ID_EX_PERF_EN setting of the build.
// ============================================================================
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;
`ifdef ID_EX_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic              id_rs1_used, id_rs2_used;
   logic [XLEN-1:0]   id_rdata1, id_rdata2, id_imm;
   logic              id_imm_sel, id_mem_read, id_mem_write, id_reg_write;
   logic [CTRL_W-1:0] id_ctrl;
   logic              br_taken, mem_stall;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]   ex_rdata1, ex_rdata2, ex_imm;
   logic              ex_imm_sel, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              pc_stall, ifid_stall, ifid_flush;
   logic [31:0]       bubble_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_imm_sel(id_imm_sel), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .id_ctrl(id_ctrl), .br_taken(br_taken), .mem_stall(mem_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_imm_sel(ex_imm_sel), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .ex_ctrl(ex_ctrl), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
      .ifid_flush(ifid_flush), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then move 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a plain, hazard-free ID instruction.
   task automatic drive_id(input logic [4:0] rd, input logic [31:0] pc,
                           input logic mem_rd);
      id_valid     = 1'b1;
      id_pc        = pc;
      id_rd        = rd;
      id_mem_read  = mem_rd;
      id_reg_write = 1'b1;
      id_rs1       = 5'd0;
      id_rs2       = 5'd0;
      id_rs1_used  = 1'b0;
      id_rs2_used  = 1'b0;
      id_ctrl      = 8'h00;
   endtask

   initial begin
      // ---------------- reset ----------------
      rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
      id_rd = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rdata1 = '0;
      id_rdata2 = '0; id_imm = '0; id_imm_sel = 1'b0; id_mem_read = 1'b0;
      id_mem_write = 1'b0; id_reg_write = 1'b0; id_ctrl = '0;
      br_taken = 1'b0; mem_stall = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_rd", ex_rd, 0);
      check("rst_pc_stall", pc_stall, 0);
      check("rst_ifid_flush", ifid_flush, 0);
      check("rst_bubble_cnt", bubble_cnt, 0);

      // ---------------- normal flow ----------------
      drive_id(5'd5, 32'h100, 1'b0);
      id_imm = 32'h10; id_imm_sel = 1'b1; id_rdata1 = 32'hAAAA_5555;
      id_rdata2 = 32'h1234_5678; id_rs1 = 5'd1; id_rs2 = 5'd2;
      id_rs1_used = 1'b1; id_ctrl = 8'h5A; id_mem_write = 1'b1;
      #1;
      check("norm_pc_stall_pre", pc_stall, 0);
      step();
      check("norm_ex_rd", ex_rd, 5);
      check("norm_ex_imm", ex_imm, 32'h10);
      check("norm_ex_valid", ex_valid, 1);
      check("norm_ex_pc", ex_pc, 32'h100);
      check("norm_ex_rdata1", ex_rdata1, 32'hAAAA_5555);
      check("norm_ex_rdata2", ex_rdata2, 32'h1234_5678);
      check("norm_ex_rs1", ex_rs1, 1);
      check("norm_ex_ctrl", ex_ctrl, 8'h5A);
      check("norm_ex_imm_sel", ex_imm_sel, 1);
      check("norm_ex_mem_write", ex_mem_write, 1);
      check("norm_ex_reg_write", ex_reg_write, 1);
      check("norm_ifid_flush", ifid_flush, 0);
      id_imm_sel = 1'b0; id_mem_write = 1'b0;

      // ---------------- load-use ----------------
      drive_id(5'd3, 32'h104, 1'b1);          // load x3
      step();
      check("lu_ex_mem_read", ex_mem_read, 1);
      drive_id(5'd7, 32'h108, 1'b0);          // dependent: uses x3 as rs2
      id_rs1 = 5'd4; id_rs1_used = 1'b1; id_rs2 = 5'd3; id_rs2_used = 1'b1;
      id_ctrl = 8'h11;
      #1;
      check("lu_pc_stall", pc_stall, 1);
      check("lu_ifid_stall", ifid_stall, 1);
      check("lu_ifid_flush", ifid_flush, 0);
      step();
      check("lu_bub_valid", ex_valid, 0);
      check("lu_bub_rd", ex_rd, 0);
      check("lu_bub_rs2", ex_rs2, 0);
      check("lu_bub_reg_write", ex_reg_write, 0);
      check("lu_bub_mem_read", ex_mem_read, 0);
      check("lu_bub_pc", ex_pc, 0);
      check("lu_bub_ctrl", ex_ctrl, 0);
      check("lu_bubble_cnt", bubble_cnt, PERF ? 1 : 0);
      check("lu_stall_drop", pc_stall, 0);
      step();
      check("lu_dep_rd", ex_rd, 7);
      check("lu_dep_ctrl", ex_ctrl, 8'h11);
      check("lu_dep_pc", ex_pc, 32'h108);
      check("lu_dep_valid", ex_valid, 1);

      // ---------------- false hazards ----------------
      drive_id(5'd0, 32'h10C, 1'b1);          // load to x0
      step();
      id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
      #1;
      check("fh_rd0_no_stall", pc_stall, 0);
      drive_id(5'd3, 32'h110, 1'b1);          // load x3
      step();
      id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b0;
      id_rs2 = 5'd9; id_rs2_used = 1'b1; id_mem_read = 1'b0;
      #1;
      check("fh_unused_no_stall", pc_stall, 0);
      id_rs1_used = 1'b1; id_valid = 1'b0;
      #1;
      check("fh_invalid_no_stall", pc_stall, 0);

      // ---------------- branch flush during load-use ----------------
      id_valid = 1'b1;
      #1;
      check("bf_hazard_stall", pc_stall, 1);
      br_taken = 1'b1;
      #1;
      check("bf_pc_stall", pc_stall, 0);
      check("bf_ifid_flush", ifid_flush, 1);
      step();
      br_taken = 1'b0;
      #1;
      check("bf_bub_valid", ex_valid, 0);
      check("bf_bub_rd", ex_rd, 0);
      check("bf_flush_cnt", flush_cnt, PERF ? 1 : 0);
      check("bf_bubble_cnt", bubble_cnt, PERF ? 1 : 0);

      // ---------------- memory freeze ----------------
      drive_id(5'd9, 32'h200, 1'b0);
      step();
      check("mf_load_rd", ex_rd, 9);
      mem_stall = 1'b1; br_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(5'(10 + i), 32'h300 + 32'(4 * i), 1'b0);
         #1;
         check("mf_pc_stall", pc_stall, 1);
         check("mf_ifid_stall", ifid_stall, 1);
         check("mf_ifid_flush", ifid_flush, 0);
         step();
         check("mf_ex_rd", ex_rd, 9);
         check("mf_ex_pc", ex_pc, 32'h200);
      end
      check("mf_flush_cnt", flush_cnt, PERF ? 1 : 0);
      check("mf_bubble_cnt", bubble_cnt, PERF ? 1 : 0);
      mem_stall = 1'b0; br_taken = 1'b0;
      drive_id(5'd12, 32'h400, 1'b0);
      step();
      check("mf_release_rd", ex_rd, 12);
      check("mf_release_pc", ex_pc, 32'h400);

      // ---------------- reset during load-use stall ----------------
      drive_id(5'd3, 32'h404, 1'b1);
      step();
      drive_id(5'd6, 32'h408, 1'b0);
      id_rs1 = 5'd3; id_rs1_used = 1'b1;
      #1;
      check("rs_stall_before", pc_stall, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rs_ex_valid", ex_valid, 0);
      check("rs_ex_rd", ex_rd, 0);
      check("rs_ex_pc", ex_pc, 0);
      check("rs_ex_mem_read", ex_mem_read, 0);
      check("rs_pc_stall", pc_stall, 0);
      check("rs_ifid_flush", ifid_flush, 0);
      check("rs_bubble_cnt", bubble_cnt, 0);
      check("rs_flush_cnt", flush_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Keep the run bounded even if the stimulus sequence stalls.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the 5-stage RISC-V core, with load-use hazard detection and branch-flush bubble insertion. It latches decoded fields from ID and presents them to EX. Its `ex_rs1`, `ex_rs2`, `ex_imm_sel` and `ex_mem_write` outputs are the operand-select inputs of the EX-stage forwarding unit. It also drives the PC / IF-ID stall and flush controls.

## Interface
- `XLEN`, 32, datapath width
- `CTRL_W`, 8, width of the opaque ALU/branch control bundle
- `clk` input 1: clock
- `rst` input 1: reset; **synchronous, active-high, one clock**
- `id_valid` input 1: ID holds a real instruction
- `id_pc` input XLEN: PC of the ID instruction
- `id_rs1`, `id_rs2`, `id_rd` input 5 each: register indices
- `id_rs1_used`, `id_rs2_used` input 1 each: the source is actually read
- `id_rdata1`, `id_rdata2` input XLEN: register-file read data
- `id_imm` input XLEN: sign-extended immediate
- `id_imm_sel` input 1: operand 2 is the immediate
- `id_mem_read`, `id_mem_write`, `id_reg_write` input 1 each: memory and writeback controls
- `id_ctrl` input CTRL_W: ALU op / branch type
- `br_taken` input 1: EX resolved a taken branch or jump this cycle
- `mem_stall` input 1: data memory busy; freeze the pipeline
- `ex_valid`, `ex_pc`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_rdata1`, `ex_rdata2`, `ex_imm`, `ex_imm_sel`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_ctrl` output: registered copies, same widths as the inputs
- `pc_stall` output 1: hold the PC
- `ifid_stall` output 1: hold the IF/ID register
- `ifid_flush` output 1: clear the IF/ID register
- `bubble_cnt`, `flush_cnt` output 32: performance counters (see Configuration)

## Operation
- `load_use` (combinational) = `ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))`.
- Per-edge action, highest priority first:
  1. `rst`: all `ex_*` = 0, counters = 0.
  2. `mem_stall`: hold every register, including the counters.
  3. `br_taken`: insert a bubble (kills the wrong-path instruction in ID); `flush_cnt`+1.
  4. `load_use`: insert a bubble; ID and IF are held; `bubble_cnt`+1.
  5. Otherwise load: `ex_*` <= `id_*`, `ex_valid` <= `id_valid`.
- Bubble definition: `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_imm_sel` = 0; `ex_rs1`, `ex_rs2`, `ex_rd` = 0; `ex_ctrl` = 0 (ADD/no-branch). Data fields (`pc`, `rdata`, `imm`) are zeroed.
- Because bubble indices are zero, the forwarding unit never matches on a bubble.
- Combinational outputs:
  - `pc_stall = ifid_stall = mem_stall | (load_use & ~br_taken)`
  - `ifid_flush = br_taken & ~mem_stall`
- A load whose `ex_rd==0` never stalls.
- An ID instruction with `id_valid=0` never stalls.

## Timing
- Latency: exactly 1 cycle from ID to EX.
- Load-use inserts exactly one bubble. On the next cycle the load is in MEM, `load_use` drops, and the dependent instruction advances; MEM→EX forwarding supplies the value.
- `br_taken` and `load_use` in the same cycle: the flush wins, and no stall is issued, since the ID instruction is dead.
- `mem_stall` with `br_taken` in the same cycle: nothing changes. `ifid_flush` = 0. EX holds the branch, so `br_taken` re-asserts after `mem_stall` drops.
- `rst` mid-stall: all outputs are 0 on the next cycle. After reset, `pc_stall`, `ifid_stall` and `ifid_flush` = 0 unless `mem_stall` or `br_taken` is high.
- The counters wrap from 0xFFFFFFFF to 0.

## Configuration
- `ID_EX_PERF_EN` defined: `bubble_cnt` and `flush_cnt` are implemented as described.
- `ID_EX_PERF_EN` undefined: no counter flops; both outputs are constant 0. All other behaviour is identical.

## Test plan
- Normal flow: `id_valid=1`, `id_rd=5`, `id_imm=0x10`, `id_reg_write=1`, no hazards → next cycle `ex_rd=5`, `ex_imm=0x10`, `ex_valid=1`; stalls and flush = 0.
- Load-use: EX holds load `ex_rd=3`; ID has `id_rs2=3`, `id_rs2_used=1` → `pc_stall=ifid_stall=1` for one cycle. EX gets a bubble (`ex_rd=0`, `ex_reg_write=0`), then the dependent instruction enters EX. `bubble_cnt`=1 with `ID_EX_PERF_EN`.
- False hazard: load with `ex_rd=0` and `id_rs1=0`; or `id_rs1=3` with `id_rs1_used=0` → no stall.
- Branch flush during load-use: `br_taken=1` while `load_use=1` → `ifid_flush=1`, `pc_stall=0`, EX gets a bubble, `flush_cnt`+1, `bubble_cnt` unchanged.
- Memory freeze: `mem_stall=1` for 3 cycles with changing `id_*` → `ex_*` frozen, `pc_stall=1`, counters frozen. Release loads the current `id_*`.
- Reset: assert `rst` during a load-use stall → next cycle all `ex_*`, counters and stall/flush outputs = 0. Without `ID_EX_PERF_EN`, counters read 0 throughout.
